// File: rtl/run_seq_pkg.sv
// rtl/run_seq_pkg.sv - shared state type, address defaults and byte helpers for run_sequencer
package run_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        READ,
        FIN
    } seq_state_t;

    // Default data-memory byte addresses of operand A MSB and result MSB.
    localparam logic [7:0] OP_BASE_DEF  = 8'd128;
    localparam logic [7:0] RES_BASE_DEF = 8'd132;

    // Bytes written per job (two 16-bit operands) and bytes read back (one 16-bit result).
    localparam int OP_BYTES  = 4;
    localparam int RES_BYTES = 2;

    // Big-endian byte idx of the packed {op_a, op_b} word: 0 = op_a MSB .. 3 = op_b LSB.
    function automatic logic [7:0] op_byte(input logic [31:0] ops, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = ops[31:24];
            2'd1:    b = ops[23:16];
            2'd2:    b = ops[15:8];
            default: b = ops[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// rtl/seq_watchdog.sv - loadable saturating down-counter with clear, enable and terminal-count flag
// Ports:
//   clk, reset    clock, synchronous active-low reset
//   clr           force count to zero
//   load/load_val load a start value (wins over en)
//   en            decrement by one, saturating at zero
//   tc            count is zero
module seq_watchdog #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/run_sequencer.sv
// rtl/run_sequencer.sv - load/run/unload job sequencer for the tinyarch core
// Optional build macro: RUN_TIMEOUT_EN (RUN watchdog of TIMEOUT_CYC cycles).
// Ports:
//   clk, reset              clock, synchronous active-low reset
//   start, op_a, op_b       host job request and operands (sampled in IDLE)
//   busy, result_valid      job in progress / one-cycle completion pulse
//   result, cycles          result word and RUN cycle count (held until next start)
//   timeout_err             job aborted by the watchdog
//   core_req, core_done     core hold (1) / run (0) and core completion flag
//   mem_sel, mem_wr_en      data-memory port ownership and byte write strobe
//   mem_addr, mem_wdata     byte address and write data
//   mem_rdata               registered read data, one cycle after mem_addr
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter logic [7:0]  OP_BASE     = OP_BASE_DEF,
    parameter logic [7:0]  RES_BASE    = RES_BASE_DEF,
    parameter int unsigned TIMEOUT_CYC = 25000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        busy,
    output logic        result_valid,
    output logic [15:0] result,
    output logic [15:0] cycles,
    output logic        timeout_err,
    output logic        core_req,
    input  logic        core_done,
    output logic        mem_sel,
    output logic        mem_wr_en,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    seq_state_t  state, state_n;
    logic [1:0]  idx, idx_n;      // LOAD byte / READ phase; in RUN, 0 marks the first cycle
    logic [31:0] ops, ops_n;      // captured {op_a, op_b}
    logic        wd_tc;
    logic        timeout_hit;
    logic        busy_n, valid_n, core_req_n, mem_sel_n, mem_wr_en_n;
    logic [7:0]  addr_n, wdata_n;

`ifdef RUN_TIMEOUT_EN
    seq_watchdog #(
        .WIDTH(16)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (state == IDLE),
        .load    (state == LOAD),
        .load_val(16'(TIMEOUT_CYC - 1)),
        .en      (state == RUN),
        .tc      (wd_tc)
    );
`else
    // No watchdog: RUN waits for core_done indefinitely, whatever TIMEOUT_CYC says.
    assign wd_tc = 1'b0 && (TIMEOUT_CYC != 0);
`endif

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        ops_n       = ops;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = LOAD;
                    idx_n   = '0;
                    ops_n   = {op_a, op_b};
                end
            end
            LOAD: begin
                if (idx == 2'(OP_BYTES - 1)) begin
                    state_n = RUN;
                    idx_n   = '0;
                end else begin
                    idx_n = idx + 2'd1;
                end
            end
            RUN: begin
                // A done still high from the previous job is masked on the first cycle.
                if (idx == '0) begin
                    idx_n = 2'd1;
                end
                if ((idx != '0) && core_done) begin
                    state_n = READ;
                    idx_n   = '0;
                end else if (wd_tc) begin
                    state_n     = FIN;
                    timeout_hit = 1'b1;
                end
            end
            READ: begin
                if (idx == 2'(RES_BYTES)) begin
                    state_n = FIN;
                end else begin
                    idx_n = idx + 2'd1;
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Outputs are decoded from the next state and registered with it.
        busy_n      = (state_n != IDLE);
        valid_n     = 1'b0;
        core_req_n  = 1'b1;
        mem_sel_n   = 1'b0;
        mem_wr_en_n = 1'b0;
        addr_n      = '0;
        wdata_n     = '0;
        case (state_n)
            LOAD: begin
                mem_sel_n   = 1'b1;
                mem_wr_en_n = 1'b1;
                addr_n      = OP_BASE + {6'd0, idx_n};
                wdata_n     = op_byte(ops_n, idx_n);
            end
            RUN:  core_req_n = 1'b0;
            READ: begin
                mem_sel_n = 1'b1;
                addr_n    = (idx_n == '0) ? RES_BASE : RES_BASE + 8'd1;
            end
            FIN:  valid_n = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            idx          <= '0;
            ops          <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            core_req     <= 1'b1;
            mem_sel      <= 1'b0;
            mem_wr_en    <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            result       <= '0;
            cycles       <= '0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            ops          <= ops_n;
            busy         <= busy_n;
            result_valid <= valid_n;
            core_req     <= core_req_n;
            mem_sel      <= mem_sel_n;
            mem_wr_en    <= mem_wr_en_n;
            mem_addr     <= addr_n;
            mem_wdata    <= wdata_n;

            if ((state == IDLE) && start) begin
                cycles      <= '0;
                timeout_err <= 1'b0;
            end else if ((state == RUN) && (cycles != 16'hFFFF)) begin
                cycles <= cycles + 16'd1;
            end

            if (timeout_hit) begin
                timeout_err <= 1'b1;
                result      <= '0;
            end

            // Read data lags the address by one cycle: MSB arrives in r1, LSB in r2.
            if ((state == READ) && (idx == 2'd1)) begin
                result[15:8] <= mem_rdata;
            end
            if ((state == READ) && (idx == 2'd2)) begin
                result[7:0] <= mem_rdata;
            end
        end
    end

endmodule
